kbd_mouse_feeder: RTL and testbench
===================================

// Module: kbd_mouse_feeder
// PURPOSE
//  Upstream feeder for the minimig core's keyboard/mouse input port. Takes Amiga raw
//  keycodes and relative mouse motion from the MCU/HID side and queues them.
//  Keycodes are FIFO-buffered; mouse motion is accumulated.
//  Emits one byte at a time on kbd_mouse_level/type/data using the toggle-level
//  protocol, paced by a minimum gap between bytes.
// PARAMETERS
//  FIFO_DEPTH  8     keycode FIFO entries; power of 2, >=2
//  GAP_CYCLES  2048  min clk_sys cycles between level toggles (~71us @28.69MHz); >=2
//  ACC_W       10    signed width of each mouse motion accumulator
// PORTS
//  clk_sys          in   1  system clock, 28.6875 MHz
//  reset            in   1  synchronous, active-high reset
//  kbd_strobe       in   1  1-cycle pulse: kbd_code valid
//  kbd_code         in   8  Amiga raw keycode; bit7=1 means key release
//  mouse_strobe     in   1  1-cycle pulse: mouse_dx/dy valid
//  mouse_dx         in   8  signed X motion delta
//  mouse_dy         in   8  signed Y motion delta
//  kbd_mouse_level  out  1  toggles once per emitted byte
//  kbd_mouse_type   out  2  0=mouse Y, 1=mouse X, 2=keyboard; 3 never driven
//  kbd_mouse_data   out  8  payload byte for the current toggle
//  kbd_overflow     out  1  sticky: a keycode was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: level=0, type=0, data=0, overflow=0; FIFO empty; both accumulators=0; state IDLE.
//   Reset mid-GAP aborts the gap with no extra toggle.
//  Keycode FIFO:
//   - kbd_strobe writes kbd_code at the clock edge.
//   - Full and no pop that cycle: code dropped, overflow set.
//   - Full with a pop in the same cycle: push is accepted.
//  Accumulators accX/accY, ACC_W-bit signed:
//   - On mouse_strobe add the sign-extended delta.
//   - Result saturates at +/-(2^(ACC_W-1)-1).
//   - A strobe in the same cycle as an emit of that axis:
//     acc_next = sat(acc + delta - sent).
//  FSM has two states.
//   IDLE:
//    - Choose a source with strict priority: FIFO non-empty > accX!=0 > accY!=0.
//    - If a source is chosen, emit on the next edge and go to GAP with gap_cnt=GAP_CYCLES-1.
//    - Emit = toggle level, set type, set data in the same edge.
//   Emit payloads:
//    - Keyboard: pop FIFO head; type=2, data=code.
//    - Mouse X: sent=clip(accX, -127..+127); type=1, data=sent[7:0]; accX -= sent.
//    - Mouse Y: same as X using accY; type=0.
//   GAP:
//    - Decrement gap_cnt each cycle; at 0 return to IDLE.
//    - Toggle spacing is therefore exactly GAP_CYCLES cycles when work is continuous.
//  Latency: kbd_strobe at edge N with FIFO empty in IDLE -> toggle visible after edge N+1.
//  Output hold: type/data change only on toggle edges; held stable between toggles.
//   The consumer may sample on any edge after detecting the toggle.
//  Zero motion: a strobe with dx=dy=0 causes no emit.
//  Wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty derive from the MSB compare.
// TESTING
//  1 Reset, kbd_strobe code=0x45 -> one edge later level 0->1, type=2, data=0x45.
//    No further toggle follows.
//  2 mouse_dx=+100 (8'h64) -> X +100 emitted (type=1, data=0x64).
//    After GAP, dx=-128 -> X data 0x81 (-127), then after GAP X data 0xFF (-1).
//  3 Same-cycle kbd_strobe 0x20 and mouse_strobe dx=5,dy=-3 -> emit order:
//    kbd 0x20, X 0x05, Y 0xFD. Toggles are exactly GAP_CYCLES apart.
//  4 During a gap, 9 kbd_strobes 0x01..0x09 -> 0x01..0x08 emitted in order,
//    0x09 dropped, overflow=1 until reset.
//  5 Sixty mouse_strobes dx=+127 -> accX saturates at +511.
//    Emits 0x7F,0x7F,0x7F,0x7F,0x03 (total +511).
//  6 Reset asserted in GAP with FIFO holding 3 codes -> all outputs 0.
//    No toggle for 10*GAP_CYCLES cycles after release.

Source files
------------

// File: rtl/kbd_mouse_feeder.sv
// kbd_mouse_feeder
//   Upstream feeder for the minimig keyboard/mouse input port. Amiga raw
//   keycodes are queued in a small FIFO. Relative mouse motion is summed into
//   two saturating signed accumulators. One byte at a time is emitted on the
//   toggle-level interface, with at least GAP_CYCLES clocks between toggles.
//
// Ports
//   clk_sys          system clock
//   reset            synchronous, active-high reset
//   kbd_strobe       1-cycle pulse, kbd_code valid
//   kbd_code         Amiga raw keycode (bit7 = key release)
//   mouse_strobe     1-cycle pulse, mouse_dx/mouse_dy valid
//   mouse_dx         signed X motion delta
//   mouse_dy         signed Y motion delta
//   kbd_mouse_level  toggles once per emitted byte
//   kbd_mouse_type   0 = mouse Y, 1 = mouse X, 2 = keyboard
//   kbd_mouse_data   payload byte, held stable between toggles
//   kbd_overflow     sticky flag, a keycode was dropped on a full FIFO

module kbd_mouse_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2048,
    parameter int ACC_W      = 10
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       kbd_strobe,
    input  logic [7:0] kbd_code,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    output logic       kbd_mouse_level,
    output logic [1:0] kbd_mouse_type,
    output logic [7:0] kbd_mouse_data,
    output logic       kbd_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES);
    // Extra headroom so acc + delta - sent never wraps before saturation.
    localparam int EW = ACC_W + 2;

    localparam logic signed [EW-1:0] SAT_HI  = EW'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [EW-1:0] SAT_LO  = -SAT_HI;
    localparam logic signed [EW-1:0] CLIP_HI = EW'(127);
    localparam logic signed [EW-1:0] CLIP_LO = -CLIP_HI;

    localparam logic [1:0] TYPE_MOUSE_Y = 2'd0;
    localparam logic [1:0] TYPE_MOUSE_X = 2'd1;
    localparam logic [1:0] TYPE_KBD     = 2'd2;

    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);
    localparam logic [GW-1:0] GAP_TOP = GW'(GAP_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_KBD,
        SRC_X,
        SRC_Y
    } src_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic signed [EW-1:0] sext_acc(input logic signed [ACC_W-1:0] a);
        return {{2{a[ACC_W-1]}}, a};
    endfunction

    function automatic logic signed [EW-1:0] sext8(input logic [7:0] b);
        return {{(EW - 8){b[7]}}, b};
    endfunction

    // Largest byte-sized step toward zero: clip to -127..+127.
    function automatic logic [7:0] clip127(input logic signed [ACC_W-1:0] a);
        logic signed [EW-1:0] e;
        e = sext_acc(a);
        if (e > CLIP_HI)
            return 8'h7F;
        else if (e < CLIP_LO)
            return 8'h81;
        else
            return e[7:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[ACC_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[ACC_W-1:0];
        else
            return v[ACC_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state, state_next;
    logic [GW-1:0]            gap_cnt, gap_next;
    src_t                     src;

    logic [7:0]               fifo_mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr, rd_ptr;
    logic                     fifo_empty, fifo_full;
    logic [7:0]               fifo_head;
    logic                     pop, push_ok;

    logic signed [ACC_W-1:0]  acc_x, acc_y;
    logic signed [EW-1:0]     acc_x_sum, acc_y_sum;
    logic [7:0]               sent_x, sent_y;
    logic                     emit_x, emit_y;

    logic [1:0]               emit_type;
    logic [7:0]               emit_data;

    // ------------------------------------------------------------------
    // Keycode FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    assign pop     = (src == SRC_KBD);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = kbd_strobe && (!fifo_full || pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok)
            fifo_mem[wr_ptr[AW-1:0]] <= kbd_code;
    end

    // ------------------------------------------------------------------
    // Mouse accumulators
    // ------------------------------------------------------------------
    assign sent_x = clip127(acc_x);
    assign sent_y = clip127(acc_y);
    assign emit_x = (src == SRC_X);
    assign emit_y = (src == SRC_Y);

    always_comb begin
        acc_x_sum = sext_acc(acc_x)
                  + (mouse_strobe ? sext8(mouse_dx) : '0)
                  - (emit_x       ? sext8(sent_x)   : '0);
        acc_y_sum = sext_acc(acc_y)
                  + (mouse_strobe ? sext8(mouse_dy) : '0)
                  - (emit_y       ? sext8(sent_y)   : '0);
    end

    // ------------------------------------------------------------------
    // FSM: next state and source selection
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        src        = SRC_NONE;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty)
                    src = SRC_KBD;
                else if (acc_x != '0)
                    src = SRC_X;
                else if (acc_y != '0)
                    src = SRC_Y;
                if (src != SRC_NONE) begin
                    state_next = ST_GAP;
                    gap_next   = GAP_TOP;
                end
            end
            ST_GAP: begin
                // Leave GAP on the edge where the count reaches zero, so
                // back-to-back toggles are exactly GAP_CYCLES apart.
                gap_next = gap_cnt - GAP_ONE;
                if (gap_cnt == GAP_ONE)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                gap_next   = '0;
            end
        endcase
    end

    always_comb begin
        emit_type = '0;
        emit_data = '0;
        case (src)
            SRC_KBD: begin
                emit_type = TYPE_KBD;
                emit_data = fifo_head;
            end
            SRC_X: begin
                emit_type = TYPE_MOUSE_X;
                emit_data = sent_x;
            end
            SRC_Y: begin
                emit_type = TYPE_MOUSE_Y;
                emit_data = sent_y;
            end
            default: begin
                emit_type = '0;
                emit_data = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= ST_IDLE;
            gap_cnt         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            acc_x           <= '0;
            acc_y           <= '0;
            kbd_mouse_level <= 1'b0;
            kbd_mouse_type  <= '0;
            kbd_mouse_data  <= '0;
            kbd_overflow    <= 1'b0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
            acc_x   <= sat(acc_x_sum);
            acc_y   <= sat(acc_y_sum);

            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (kbd_strobe && !push_ok)
                kbd_overflow <= 1'b1;

            if (src != SRC_NONE) begin
                kbd_mouse_level <= ~kbd_mouse_level;
                kbd_mouse_type  <= emit_type;
                kbd_mouse_data  <= emit_data;
            end
        end
    end

endmodule

// File: tb/tb_kbd_mouse_feeder.sv
// tb_kbd_mouse_feeder
//   Self-checking bench for kbd_mouse_feeder. A behavioural model (queue for
//   the keycodes, plain integers for the accumulators, an "earliest next emit"
//   cycle number for pacing) predicts every emitted byte and its cycle and
//   pushes it into a scoreboard queue; a monitor pops and compares on each
//   level toggle. Directed scenarios also compare the observed byte stream
//   against hand-derived constants.

module tb_kbd_mouse_feeder;

    localparam int FD  = 8;
    localparam int G   = 64;
    localparam int AW  = 10;
    localparam int LIM = 511;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kbd_strobe = 1'b0;
    logic [7:0] kbd_code = '0;
    logic       mouse_strobe = 1'b0;
    logic [7:0] mouse_dx = '0;
    logic [7:0] mouse_dy = '0;
    logic       kbd_mouse_level;
    logic [1:0] kbd_mouse_type;
    logic [7:0] kbd_mouse_data;
    logic       kbd_overflow;

    kbd_mouse_feeder #(
        .FIFO_DEPTH (FD),
        .GAP_CYCLES (G),
        .ACC_W      (AW)
    ) dut (
        .clk_sys         (clk),
        .reset           (reset),
        .kbd_strobe      (kbd_strobe),
        .kbd_code        (kbd_code),
        .mouse_strobe    (mouse_strobe),
        .mouse_dx        (mouse_dx),
        .mouse_dy        (mouse_dy),
        .kbd_mouse_level (kbd_mouse_level),
        .kbd_mouse_type  (kbd_mouse_type),
        .kbd_mouse_data  (kbd_mouse_data),
        .kbd_overflow    (kbd_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h required 'h%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int     code;   // type*256 + data
        longint cyc;
    } exp_t;

    int     m_fifo[$];
    int     m_ax = 0;
    int     m_ay = 0;
    longint m_next_ok = 0;
    bit     m_ovf = 1'b0;
    longint cyc = 0;
    exp_t   sbq[$];
    int     obs[$];
    int     exp_obs[$];

    function automatic int sat_m(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic int clip_m(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    always @(posedge clk) begin : model
        int   sx, sy, dx, dy;
        bit   em;
        exp_t e;
        cyc++;
        if (reset) begin
            m_fifo.delete();
            m_ax = 0;
            m_ay = 0;
            m_next_ok = 0;
            m_ovf = 1'b0;
        end else begin
            sx = 0;
            sy = 0;
            em = 1'b0;
            e.code = 0;
            if (cyc >= m_next_ok) begin
                if (m_fifo.size() > 0) begin
                    e.code = 512 + m_fifo.pop_front();
                    em = 1'b1;
                end else if (m_ax != 0) begin
                    sx = clip_m(m_ax);
                    e.code = 256 + (sx & 255);
                    em = 1'b1;
                end else if (m_ay != 0) begin
                    sy = clip_m(m_ay);
                    e.code = sy & 255;
                    em = 1'b1;
                end
                if (em) begin
                    e.cyc = cyc;
                    sbq.push_back(e);
                    m_next_ok = cyc + G;
                end
            end
            if (kbd_strobe) begin
                if (m_fifo.size() < FD) m_fifo.push_back(int'(kbd_code));
                else m_ovf = 1'b1;
            end
            dx = mouse_strobe ? int'($signed(mouse_dx)) : 0;
            dy = mouse_strobe ? int'($signed(mouse_dy)) : 0;
            m_ax = sat_m(m_ax + dx - sx);
            m_ay = sat_m(m_ay + dy - sy);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic prev_lvl = 1'b0;
    int   last_tw  = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        int   tw;
        tw = int'(kbd_mouse_type) * 256 + int'(kbd_mouse_data);
        if (reset) begin
            prev_lvl = 1'b0;
            last_tw  = 0;
        end else if (kbd_mouse_level !== prev_lvl) begin
            prev_lvl = kbd_mouse_level;
            last_tw  = tw;
            obs.push_back(tw);
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_toggle: got type/data 'h%0h at cycle %0d, required no toggle", tw, cyc);
            end else begin
                e = sbq.pop_front();
                chk("emit_type_data", tw, e.code);
                chk("emit_cycle", int'(cyc), int'(e.cyc));
                chk("overflow_at_emit", int'(kbd_overflow), int'(m_ovf));
            end
        end else begin
            chk("hold_type_data", tw, last_tw);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_level", int'(kbd_mouse_level), 0);
        chk("reset_type", int'(kbd_mouse_type), 0);
        chk("reset_data", int'(kbd_mouse_data), 0);
        chk("reset_overflow", int'(kbd_overflow), 0);
        reset = 1'b0;
        obs.delete();
    endtask

    task automatic kbd_burst(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            kbd_strobe = 1'b1;
            kbd_code   = 8'(first + i);
        end
        @(negedge clk);
        kbd_strobe = 1'b0;
    endtask

    task automatic mouse_burst(input int dx, input int dy, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mouse_strobe = 1'b1;
            mouse_dx     = 8'(dx);
            mouse_dy     = 8'(dy);
        end
        @(negedge clk);
        mouse_strobe = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 10000 && !done; i++) begin
            if (m_fifo.size() == 0 && m_ax == 0 && m_ay == 0 &&
                cyc >= m_next_ok && sbq.size() == 0)
                done = 1'b1;
            else
                @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain_timeout: got %0d pending emits, required 0", name, sbq.size());
        end
        idle(2);
    endtask

    task automatic check_obs(input string name);
        chk({name, "_count"}, obs.size(), exp_obs.size());
        for (int i = 0; i < exp_obs.size(); i++)
            chk($sformatf("%s_%0d", name, i), (i < obs.size()) ? obs[i] : -1, exp_obs[i]);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        // 1: single keycode, one-edge latency, no follow-up toggle
        do_reset();
        @(negedge clk);
        kbd_strobe = 1'b1;
        kbd_code   = 8'h45;
        @(negedge clk);
        kbd_strobe = 1'b0;
        chk("t1_no_toggle_at_push_edge", int'(kbd_mouse_level), 0);
        @(negedge clk);
        chk("t1_level", int'(kbd_mouse_level), 1);
        chk("t1_type", int'(kbd_mouse_type), 2);
        chk("t1_data", int'(kbd_mouse_data), 'h45);
        idle(3 * G);
        chk("t1_level_stays", int'(kbd_mouse_level), 1);
        exp_obs = {};
        exp_obs.push_back('h245);
        check_obs("t1");

        // 2: X motion +100, then -128 split into -127 and -1
        do_reset();
        mouse_burst(100, 0, 1);
        drain("t2a");
        mouse_burst(-128, 0, 1);
        drain("t2b");
        exp_obs = {};
        exp_obs.push_back('h164);
        exp_obs.push_back('h181);
        exp_obs.push_back('h1FF);
        check_obs("t2");

        // 3: keyboard beats X beats Y
        do_reset();
        @(negedge clk);
        kbd_strobe   = 1'b1;
        kbd_code     = 8'h20;
        mouse_strobe = 1'b1;
        mouse_dx     = 8'd5;
        mouse_dy     = 8'hFD;
        @(negedge clk);
        kbd_strobe   = 1'b0;
        mouse_strobe = 1'b0;
        drain("t3");
        exp_obs = {};
        exp_obs.push_back('h220);
        exp_obs.push_back('h105);
        exp_obs.push_back('h0FD);
        check_obs("t3");

        // 4: nine keycodes during a gap, ninth dropped
        do_reset();
        mouse_burst(1, 0, 1);
        kbd_burst(1, 9);
        chk("t4_overflow_set", int'(kbd_overflow), 1);
        drain("t4");
        chk("t4_overflow_sticky", int'(kbd_overflow), 1);
        exp_obs = {};
        exp_obs.push_back('h101);
        for (int i = 1; i <= 8; i++) exp_obs.push_back('h200 + i);
        check_obs("t4");

        // 5: accumulator saturation at +511 while a gap is running
        do_reset();
        kbd_burst('h33, 1);
        mouse_burst(127, 0, 60);
        drain("t5");
        exp_obs = {};
        exp_obs.push_back('h233);
        for (int i = 0; i < 4; i++) exp_obs.push_back('h17F);
        exp_obs.push_back('h103);
        check_obs("t5");

        // 6: reset in GAP with three queued codes
        do_reset();
        kbd_burst('h11, 4);
        idle(5);
        chk("t6_model_queued", m_fifo.size(), 3);
        do_reset();
        idle(10 * G);
        chk("t6_no_toggle_after_reset", obs.size(), 0);
        chk("t6_level_low", int'(kbd_mouse_level), 0);

        // 7: random traffic, sparse then dense keycodes
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            kbd_strobe   = ($urandom_range(0, 79) == 0);
            kbd_code     = 8'($urandom);
            mouse_strobe = ($urandom_range(0, 15) == 0);
            mouse_dx     = 8'($urandom);
            mouse_dy     = 8'($urandom);
        end
        @(negedge clk);
        kbd_strobe   = 1'b0;
        mouse_strobe = 1'b0;
        drain("t7a");
        chk("t7a_overflow", int'(kbd_overflow), int'(m_ovf));

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            kbd_strobe   = ($urandom_range(0, 3) == 0);
            kbd_code     = 8'($urandom);
            mouse_strobe = ($urandom_range(0, 7) == 0);
            mouse_dx     = 8'($urandom_range(100, 255));
            mouse_dy     = 8'($urandom_range(0, 127));
        end
        @(negedge clk);
        kbd_strobe   = 1'b0;
        mouse_strobe = 1'b0;
        drain("t7b");
        chk("t7b_overflow", int'(kbd_overflow), int'(m_ovf));

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
